fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the Y86-64 fetch stage. Owns the PC register and issues 10-byte instruction-memory reads through a req/ack handshake.
- Computes instruction length, valP and the predicted next PC. Applies mispredict and ret redirects, and hands fetched instructions to decode through a valid/ready handshake.
- Sits between instruction memory and the decode pipeline register. The combinational field split (icode/ifun/rA/rB/valC) is done downstream from the fetch_ctrl outputs.

Parameters:
- RESET_PC, 64'h0, PC loaded on reset.
- ACK_TIMEOUT, 16, cycles to wait for imem_ack before flagging ADR status; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- imem_req  out  1  read request; held until imem_ack
- imem_addr  out  64  read address (current PC)
- imem_ack  in  1  read data valid, one-cycle pulse
- imem_data  in  80  instruction bytes, byte 0 in bits [7:0]
- imem_err  in  1  address error, qualified by imem_ack
- f_valid  out  1  instruction available to decode
- f_ready  in  1  decode accepts (pipeline not stalled)
- f_ins  out  80  captured instruction bytes
- f_pc  out  64  PC of f_ins
- f_valP  out  64  f_pc + instruction length
- f_stat  out  2  AOK=0, HLT=1, ADR=2, INS=3
- redir_mis  in  1  branch mispredict; target on redir_mis_pc
- redir_mis_pc  in  64  fall-through PC from memory stage
- redir_ret  in  1  ret completed; target on redir_ret_pc
- redir_ret_pc  in  64  return address from writeback
- halted  out  1  fetch stopped

Behaviour:
- Reset (async): state=REQ_WAIT, pc=RESET_PC, imem_req=1, f_valid=0, f_stat=AOK, halted=0, timeout counter=0, discard flag=0.
- States:
  - REQ_WAIT: imem_req=1, imem_addr=pc.
  - HOLD: f_valid=1, outputs stable.
  - RET_WAIT: no request; waits for redir_ret.
  - HALTED.
- REQ_WAIT on imem_ack:
  - If the discard flag is set, drop the data, clear the flag and stay in REQ_WAIT; the new pc was issued on the next cycle.
  - Otherwise capture the data into f_ins/f_pc and go to HOLD. Registered latency: f_valid rises the cycle after imem_ack.
- Length by icode:
  - halt/nop/ret: 1.
  - rrmovq/opq/pushq/popq: 2.
  - jxx/call: 9.
  - irmovq/rmmovq/mrmovq: 10.
  - Any other icode: 1, with f_stat=INS.
  - valP arithmetic is 64-bit modulo 2^64 (wrap-around permitted).
- f_stat: imem_err gives ADR, icode>0xB gives INS, halt gives HLT, otherwise AOK.
- Handoff: HOLD with f_ready=1 completes the handoff, then:
  - next pc = predicted PC (jxx/call gives valC; otherwise valP);
  - ret goes to RET_WAIT;
  - f_stat≠AOK goes to HALTED;
  - otherwise REQ_WAIT with the new pc.
- HOLD with f_ready=0: hold all outputs unchanged.
- Redirects (any state except HALTED):
  - redir_ret has priority over redir_mis when both are asserted.
  - The redirect sets pc=target, drops f_valid, and enters REQ_WAIT.
  - If a request is outstanding (REQ_WAIT with no ack this cycle), set the discard flag so the stale ack is dropped.
  - A redirect coincident with an ack: the ack data is dropped and the request is reissued next cycle.
- Timeout: if imem_ack is missing for ACK_TIMEOUT consecutive cycles in REQ_WAIT, set f_stat=ADR, set f_valid=1, and go to HOLD (treated as an error instruction).
- HALTED: halted=1, imem_req=0, f_valid=0. Only rst exits.
- Reset mid-request abandons the request; the memory must tolerate imem_req falling without an ack.

Optional Feature:
- Macro: FETCH_BTFNT_EN.
- When defined, jxx prediction is backward-taken/forward-not-taken: valC<f_pc predicts valC, otherwise valP. Unconditional jmp (ifun=0) and call always predict valC.
- Without the macro, all jxx predict valC (always taken).

Decomposition:
- Shared defines header holds:
  - icode constants (IHALT..IPOPQ, INOP);
  - stat codes;
  - field slice macros (ICODE, IFUN, VALC, NO_REGIDS_VALC);
  - the QWORD width macro.
- Sub-module fetch_predict (combinational) takes the instruction bytes and pc and produces length, valP, predicted PC and stat. The fetch_ctrl FSM instantiates it once.

Test Plan:
1. Reset with RESET_PC=0x100 and imem returning irmovq (30 F2 + 8-byte valC) after 2 cycles -> imem_addr=0x100; f_valid the cycle after ack; f_valP=0x10A; next imem_addr=0x10A.
2. Reset with RESET_PC=0x100, jxx with valC=0x40 at pc 0x100 -> next fetch address 0x40 (always-taken); with FETCH_BTFNT_EN, jle (ifun≠0) at 0x100 with valC=0x200 -> next fetch 0x109.
3. f_ready=0 for 5 cycles in HOLD -> f_ins/f_pc stable, no imem_req; f_ready=1 -> advance.
4. redir_mis asserted while request outstanding at 0x50, target 0x80 -> the stale ack is dropped, the next accepted instruction has f_pc=0x80, and f_valid never shows the 0x50 data.
5. ret fetched -> RET_WAIT, imem_req=0; redir_ret with target 0x30 -> fetch 0x30. Simultaneous redir_ret(0x30)/redir_mis(0x90) -> 0x30 wins.
6. halt -> f_stat=HLT, then halted=1 and no further requests. imem_err on ack -> f_stat=ADR. icode 0xE -> f_stat=INS. ACK_TIMEOUT=4 with no ack -> f_stat=ADR after 4 cycles.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared Y86-64 fetch constants, state encodings and field slices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_ctrl_pkg;

    localparam int QWORD = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [1:0] S_REQ_WAIT = 2'd0;
    localparam logic [1:0] S_HOLD     = 2'd1;
    localparam logic [1:0] S_RET_WAIT = 2'd2;
    localparam logic [1:0] S_HALTED   = 2'd3;

    function automatic logic [3:0] icode_of(input logic [79:0] ins);
        return ins[7:4];
    endfunction

    function automatic logic [3:0] ifun_of(input logic [79:0] ins);
        return ins[3:0];
    endfunction

    // Constant after the register-specifier byte (irmovq/rmmovq/mrmovq)
    function automatic logic [QWORD-1:0] valc_of(input logic [79:0] ins);
        return ins[79:16];
    endfunction

    // Constant directly after the opcode byte (jxx/call)
    function automatic logic [QWORD-1:0] no_regids_valc_of(input logic [79:0] ins);
        return ins[71:8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_predict.sv
// ============================================================================
// Module      : fetch_predict
// Description : Combinational length, valP, next-PC prediction and status.
//               FETCH_BTFNT_EN selects backward-taken/forward-not-taken jxx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_predict
    import fetch_ctrl_pkg::*;
(
    input  logic [3:0]       i_icode,
`ifdef FETCH_BTFNT_EN
    input  logic [3:0]       i_ifun,
`endif
    input  logic [QWORD-1:0] i_valc,
    input  logic [QWORD-1:0] i_pc,
    input  logic             i_err,
    output logic [QWORD-1:0] o_valp,
    output logic [QWORD-1:0] o_pred_pc,
    output logic [1:0]       o_stat
);

    logic [3:0] w_len;

    always_comb begin
        w_len = 4'd1;
        case (i_icode)
            IHALT, INOP, IRET:              w_len = 4'd1;
            IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:   w_len = 4'd2;
            IJXX, ICALL:                    w_len = 4'd9;
            IIRMOVQ, IRMMOVQ, IMRMOVQ:      w_len = 4'd10;
            default:                        w_len = 4'd1;
        endcase
    end

    assign o_valp = i_pc + {{(QWORD-4){1'b0}}, w_len};

    always_comb begin
        o_pred_pc = o_valp;
        if (i_icode == ICALL) begin
            o_pred_pc = i_valc;
        end else if (i_icode == IJXX) begin
`ifdef FETCH_BTFNT_EN
            if ((i_ifun == 4'h0) || (i_valc < i_pc)) begin
                o_pred_pc = i_valc;
            end
`else
            o_pred_pc = i_valc;
`endif
        end
    end

    always_comb begin
        o_stat = STAT_AOK;
        if (i_err) begin
            o_stat = STAT_ADR;
        end else if (i_icode > IPOPQ) begin
            o_stat = STAT_INS;
        end else if (i_icode == IHALT) begin
            o_stat = STAT_HLT;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Y86-64 fetch sequencer: PC, imem req/ack, redirects, decode
//               handoff. Optional FETCH_BTFNT_EN changes jxx prediction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          ACK_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [79:0] imem_data,
    input  logic        imem_err,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [79:0] f_ins,
    output logic [63:0] f_pc,
    output logic [63:0] f_valP,
    output logic [1:0]  f_stat,
    input  logic        redir_mis,
    input  logic [63:0] redir_mis_pc,
    input  logic        redir_ret,
    input  logic [63:0] redir_ret_pc,
    output logic        halted
);

    localparam logic [79:0] c_NOP_INS = 80'h10;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [63:0] r_pc;
    logic [63:0] r_fpc;
    logic [79:0] r_ins;
    logic        r_adr;
    logic        r_discard;
    logic [15:0] r_tcnt;

    logic        w_redir;
    logic [63:0] w_redir_pc;
    logic        w_capture;
    logic        w_handoff;
    logic        w_tmo;
    logic [63:0] w_valp;
    logic [63:0] w_pred;
    logic [1:0]  w_stat;

    fetch_predict u_predict (
        .i_icode   (icode_of(r_ins)),
`ifdef FETCH_BTFNT_EN
        .i_ifun    (ifun_of(r_ins)),
`endif
        .i_valc    (no_regids_valc_of(r_ins)),
        .i_pc      (r_fpc),
        .i_err     (r_adr),
        .o_valp    (w_valp),
        .o_pred_pc (w_pred),
        .o_stat    (w_stat)
    );

    // ret outranks mispredict; nothing redirects a halted fetch
    assign w_redir    = (r_state != S_HALTED) && (redir_ret || redir_mis);
    assign w_redir_pc = redir_ret ? redir_ret_pc : redir_mis_pc;
    assign w_capture  = (r_state == S_REQ_WAIT) && imem_ack && !r_discard && !w_redir;
    assign w_handoff  = (r_state == S_HOLD) && f_ready && !w_redir;

    generate
        if (ACK_TIMEOUT > 0) begin : g_tmo
            assign w_tmo = (r_state == S_REQ_WAIT) && !imem_ack && !w_redir &&
                           (r_tcnt == 16'(ACK_TIMEOUT - 1));
        end else begin : g_no_tmo
            assign w_tmo = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REQ_WAIT: begin
                if (w_capture || w_tmo) begin
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_handoff) begin
                    if (w_stat != STAT_AOK) begin
                        w_next = S_HALTED;
                    end else if (icode_of(r_ins) == IRET) begin
                        w_next = S_RET_WAIT;
                    end else begin
                        w_next = S_REQ_WAIT;
                    end
                end
            end
            default: begin
                w_next = r_state;
            end
        endcase
        if (w_redir) begin
            w_next = S_REQ_WAIT;
        end
    end

    always_comb begin
        imem_req = 1'b0;
        f_valid  = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_REQ_WAIT: imem_req = 1'b1;
            S_HOLD:     f_valid  = 1'b1;
            S_HALTED:   halted   = 1'b1;
            default:    imem_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_fpc     <= RESET_PC;
            r_ins     <= c_NOP_INS;
            r_adr     <= 1'b0;
            r_discard <= 1'b0;
            r_tcnt    <= 16'd0;
        end else begin
            if ((r_state == S_REQ_WAIT) && !imem_ack && !w_redir) begin
                r_tcnt <= r_tcnt + 16'd1;
            end else begin
                r_tcnt <= 16'd0;
            end

            if (w_redir) begin
                r_pc      <= w_redir_pc;
                // An unanswered request will still be acked with stale data
                r_discard <= (r_state == S_REQ_WAIT) && !imem_ack;
            end else begin
                if ((r_state == S_REQ_WAIT) && imem_ack) begin
                    r_discard <= 1'b0;
                end
                if (w_capture) begin
                    r_ins <= imem_data;
                    r_fpc <= r_pc;
                    r_adr <= imem_err;
                end else if (w_tmo) begin
                    r_fpc <= r_pc;
                    r_adr <= 1'b1;
                end
                if (w_handoff) begin
                    r_pc <= w_pred;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign f_ins     = r_ins;
    assign f_pc      = r_fpc;
    assign f_valP    = w_valp;
    assign f_stat    = w_stat;

endmodule

`default_nettype wire
